msrv_32_trap_sequencer: RTL and testbench

Machine-mode trap controller for the msrv_32 core. It collects exception flags from the decoder and fetch path, plus pending-interrupt state from the CSR file. It sequences trap entry and MRET return through a small state machine. Its outputs drive PC-source selection, pipeline flush, CSR update strobes (mepc, mcause, mstatus.MIE) and the decoder's `trap_taken_in`.

---
 rtl/msrv_32_trap_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_msrv_32_trap_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv_32_trap_sequencer.sv
// msrv_32 machine-mode trap sequencer: exception/interrupt
// cause selection, trap entry and MRET return sequencing.
//
// Ports:
//   clk_in, rst_n_in         clock, async active-low reset
//   stall_in                 pipeline stall (freezes state/strobes)
//   illegal_instr_in,
//   misaligned_load_in,
//   misaligned_store_in,
//   misaligned_instr_in      exception flags
//   opcode_6_to_2_in, funct3_in, funct7_in,
//   rs1_addr_in, rs2_addr_in, rd_addr_in   instruction fields
//   mie_in                   mstatus.MIE
//   meie/mtie/msie_in,
//   meip/mtip/msip_in        interrupt enables / pending bits
//   trap_taken_out           trap accepted this cycle
//   pc_src_out               00 boot, 01 mepc, 10 vector, 11 next
//   flush_out                squash in-flight instruction
//   set_epc_out, set_cause_out   CSR write strobes
//   cause_out, i_or_e_out    latched trap cause / interrupt flag
//   mie_clear_out, mie_set_out   MIE save/restore strobes
//   instret_inc_out          instruction retired
//
// Build option: define MSRV32_INTERRUPTS_EN to enable interrupt
// detection; otherwise only exceptions and MRET are handled.

module msrv_32_trap_sequencer (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       stall_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out
);

    localparam logic [1:0] ST_RESET       = 2'd0;
    localparam logic [1:0] ST_OPERATING   = 2'd1;
    localparam logic [1:0] ST_TRAP_TAKEN  = 2'd2;
    localparam logic [1:0] ST_TRAP_RETURN = 2'd3;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    logic [1:0] state;
    logic [1:0] next_state;

    // System instruction decode
    logic sys_base;
    logic is_ecall;
    logic is_ebreak;
    logic is_mret;

    assign sys_base = (opcode_6_to_2_in == 5'b11100) &&
                      (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) &&
                      (rd_addr_in == 5'd0);

    assign is_ecall  = sys_base && (funct7_in == 7'd0) &&
                       (rs2_addr_in == 5'd0);
    assign is_ebreak = sys_base && (funct7_in == 7'd0) &&
                       (rs2_addr_in == 5'd1);
    assign is_mret   = sys_base && (funct7_in == 7'b0011000) &&
                       (rs2_addr_in == 5'b00010);

    logic exc_any;

    assign exc_any = misaligned_instr_in | illegal_instr_in |
                     is_ebreak | is_ecall |
                     misaligned_load_in | misaligned_store_in;

    // Interrupt detection
    logic irq_ext;
    logic irq_sw;
    logic irq_tmr;
    logic irq_pending;

`ifdef MSRV32_INTERRUPTS_EN
    assign irq_ext     = meie_in & meip_in;
    assign irq_sw      = msie_in & msip_in;
    assign irq_tmr     = mtie_in & mtip_in;
    assign irq_pending = mie_in & (irq_ext | irq_sw | irq_tmr);
`else
    logic unused_irq;
    assign unused_irq  = ^{mie_in, meie_in, mtie_in, msie_in,
                           meip_in, mtip_in, msip_in};
    assign irq_ext     = 1'b0;
    assign irq_sw      = 1'b0;
    assign irq_tmr     = 1'b0;
    assign irq_pending = 1'b0;
`endif

    // Cause selection: interrupts beat exceptions
    logic [3:0] cause_sel;
    logic       ioe_sel;

    always_comb begin
        cause_sel = 4'd0;
        ioe_sel   = 1'b0;
        if (irq_pending) begin
            ioe_sel = 1'b1;
            if (irq_ext) begin
                cause_sel = 4'd11;
            end else if (irq_sw) begin
                cause_sel = 4'd3;
            end else begin
                cause_sel = 4'd7;
            end
        end else if (misaligned_instr_in) begin
            cause_sel = 4'd0;
        end else if (illegal_instr_in) begin
            cause_sel = 4'd2;
        end else if (is_ebreak) begin
            cause_sel = 4'd3;
        end else if (is_ecall) begin
            cause_sel = 4'd11;
        end else if (misaligned_load_in) begin
            cause_sel = 4'd4;
        end else if (misaligned_store_in) begin
            cause_sel = 4'd6;
        end
    end

    logic in_operating;
    logic accept;

    assign in_operating = (state == ST_OPERATING);
    assign accept = in_operating & !stall_in &
                    (exc_any | irq_pending);

    // Next-state logic; a trap outranks a simultaneous MRET
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET: begin
                next_state = ST_OPERATING;
            end
            ST_OPERATING: begin
                if (accept) begin
                    next_state = ST_TRAP_TAKEN;
                end else if (is_mret && !stall_in) begin
                    next_state = ST_TRAP_RETURN;
                end
            end
            ST_TRAP_TAKEN,
            ST_TRAP_RETURN: begin
                if (!stall_in) begin
                    next_state = ST_OPERATING;
                end
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_RESET;
            cause_out  <= 4'd0;
            i_or_e_out <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cause_out  <= cause_sel;
                i_or_e_out <= ioe_sel;
            end
        end
    end

    // State-decoded outputs; strobes gated by stall
    always_comb begin
        pc_src_out    = PC_BOOT;
        flush_out     = 1'b1;
        set_epc_out   = 1'b0;
        set_cause_out = 1'b0;
        mie_clear_out = 1'b0;
        mie_set_out   = 1'b0;
        case (state)
            ST_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                pc_src_out = PC_NEXT;
                flush_out  = 1'b0;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                flush_out     = 1'b1;
                set_epc_out   = !stall_in;
                set_cause_out = !stall_in;
                mie_clear_out = !stall_in;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                flush_out   = 1'b1;
                mie_set_out = !stall_in;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign trap_taken_out  = accept;
    assign instret_inc_out = in_operating & !stall_in & !accept;

endmodule

// File: tb/tb_msrv_32_trap_sequencer.sv
// Self-checking bench for msrv_32_trap_sequencer: directed
// scenarios plus randomized traffic against a behavioural model.

module tb_msrv_32_trap_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall, illegal, mis_ld, mis_st, mis_if;
    logic [4:0] opc, rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       mie, meie, mtie, msie, meip, mtip, msip;

    logic       trap_taken, flush, set_epc, set_cause;
    logic       i_or_e, mie_clear, mie_set, instret;
    logic [1:0] pc_src;
    logic [3:0] cause;

    msrv_32_trap_sequencer dut (
        .clk_in(clk), .rst_n_in(rst_n), .stall_in(stall),
        .illegal_instr_in(illegal),
        .misaligned_load_in(mis_ld),
        .misaligned_store_in(mis_st),
        .misaligned_instr_in(mis_if),
        .opcode_6_to_2_in(opc), .funct3_in(f3), .funct7_in(f7),
        .rs1_addr_in(rs1), .rs2_addr_in(rs2), .rd_addr_in(rd),
        .mie_in(mie), .meie_in(meie), .mtie_in(mtie),
        .msie_in(msie), .meip_in(meip), .mtip_in(mtip),
        .msip_in(msip),
        .trap_taken_out(trap_taken), .pc_src_out(pc_src),
        .flush_out(flush), .set_epc_out(set_epc),
        .set_cause_out(set_cause), .cause_out(cause),
        .i_or_e_out(i_or_e), .mie_clear_out(mie_clear),
        .mie_set_out(mie_set), .instret_inc_out(instret)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W_ECALL  = 32'h0000_0073;
    localparam logic [31:0] W_EBREAK = 32'h0010_0073;
    localparam logic [31:0] W_MRET   = 32'h3020_0073;
    localparam logic [31:0] W_NOP    = 32'h0000_0013;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which kind of cycle the sequencer is in
    // 0 = boot, 1 = running, 2 = trap entry, 3 = trap return
    int         m_mode  = 0;
    logic [3:0] m_cause = 4'd0;
    logic       m_ioe   = 1'b0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_word();
        return {f7, rs2, rs1, f3, rd, opc, 2'b11};
    endfunction

    task automatic set_instr(input logic [31:0] w);
        opc = w[6:2];
        rd  = w[11:7];
        f3  = w[14:12];
        rs1 = w[19:15];
        rs2 = w[24:20];
        f7  = w[31:25];
    endtask

    task automatic clear_inputs();
        stall = 0; illegal = 0; mis_ld = 0; mis_st = 0;
        mis_if = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0;
        meip = 0; mtip = 0; msip = 0;
        set_instr(W_NOP);
    endtask

    function automatic bit irq_now();
`ifdef MSRV32_INTERRUPTS_EN
        return mie && ((meie && meip) || (msie && msip) ||
                       (mtie && mtip));
`else
        return 1'b0;
`endif
    endfunction

    // Returns 1 if something traps; fills code/flag
    function automatic bit trap_cause(output logic [3:0] code,
                                      output logic ioe);
        bit         conds[6];
        logic [3:0] codes[6];
        code = 4'd0;
        ioe  = 1'b0;
        if (irq_now()) begin
            ioe = 1'b1;
            if (meie && meip)      code = 4'd11;
            else if (msie && msip) code = 4'd3;
            else                   code = 4'd7;
            return 1'b1;
        end
        conds[0] = mis_if;                   codes[0] = 4'd0;
        conds[1] = illegal;                  codes[1] = 4'd2;
        conds[2] = (instr_word() == W_EBREAK); codes[2] = 4'd3;
        conds[3] = (instr_word() == W_ECALL);  codes[3] = 4'd11;
        conds[4] = mis_ld;                   codes[4] = 4'd4;
        conds[5] = mis_st;                   codes[5] = 4'd6;
        foreach (conds[i]) begin
            if (conds[i]) begin
                code = codes[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Let inputs settle, then compare every output to the model
    task automatic settle();
        logic [3:0] c;
        logic       e;
        bit         acc;
        logic [1:0] pc_exp[4];
        #1;
        pc_exp[0] = 2'b00; pc_exp[1] = 2'b11;
        pc_exp[2] = 2'b10; pc_exp[3] = 2'b01;
        acc = (m_mode == 1) && !stall && trap_cause(c, e);
        chk("trap_taken", trap_taken, acc);
        chk("pc_src", pc_src, pc_exp[m_mode]);
        chk("flush", flush, m_mode != 1);
        chk("set_epc", set_epc, m_mode == 2 && !stall);
        chk("set_cause", set_cause, m_mode == 2 && !stall);
        chk("mie_clear", mie_clear, m_mode == 2 && !stall);
        chk("mie_set", mie_set, m_mode == 3 && !stall);
        chk("instret", instret, m_mode == 1 && !stall && !acc);
        chk("cause", cause, m_cause);
        chk("i_or_e", i_or_e, m_ioe);
    endtask

    // Clock edge: advance the model with the inputs at the edge
    task automatic advance();
        logic [3:0] c;
        logic       e;
        @(posedge clk);
        if (rst_n) begin
            case (m_mode)
                0: m_mode = 1;
                1: begin
                    if (!stall) begin
                        if (trap_cause(c, e)) begin
                            m_mode  = 2;
                            m_cause = c;
                            m_ioe   = e;
                        end else if (instr_word() == W_MRET) begin
                            m_mode = 3;
                        end
                    end
                end
                default: if (!stall) m_mode = 1;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_cause = 4'd0;
        m_ioe   = 1'b0;
    endtask

    task automatic randomize_inputs();
        int k;
        stall   = ($urandom_range(0, 3) == 0);
        illegal = ($urandom_range(0, 9) == 0);
        mis_ld  = ($urandom_range(0, 9) == 0);
        mis_st  = ($urandom_range(0, 9) == 0);
        mis_if  = ($urandom_range(0, 11) == 0);
        mie  = $urandom_range(0, 1);
        meie = $urandom_range(0, 1);
        mtie = $urandom_range(0, 1);
        msie = $urandom_range(0, 1);
        meip = ($urandom_range(0, 5) == 0);
        mtip = ($urandom_range(0, 5) == 0);
        msip = ($urandom_range(0, 5) == 0);
        k = $urandom_range(0, 5);
        case (k)
            0: set_instr(W_ECALL);
            1: set_instr(W_EBREAK);
            2, 3: set_instr(W_MRET);
            4: set_instr(W_MRET ^
                         (32'd1 << $urandom_range(7, 31)));
            default: set_instr($urandom);
        endcase
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        settle();
        chk("rst_pc_src", pc_src, 2'b00);
        chk("rst_flush", flush, 1'b1);
        chk("rst_cause", cause, 4'd0);

        // Release: one boot cycle, then running
        rst_n = 1'b1;
        settle();
        chk("boot_pc_src", pc_src, 2'b00);
        advance();
        settle();
        chk("run_pc_src", pc_src, 2'b11);
        chk("run_instret", instret, 1'b1);
        advance();

        // Illegal instruction
        illegal = 1;
        settle();
        chk("ill_trap_taken", trap_taken, 1'b1);
        advance();
        clear_inputs();
        settle();
        chk("ill_pc_src", pc_src, 2'b10);
        chk("ill_set_epc", set_epc, 1'b1);
        chk("ill_set_cause", set_cause, 1'b1);
        chk("ill_mie_clear", mie_clear, 1'b1);
        chk("ill_cause", cause, 4'd2);
        chk("ill_i_or_e", i_or_e, 1'b0);
        advance();
        settle();
        chk("ill_back_pc_src", pc_src, 2'b11);
        advance();

        // ECALL with misaligned store
        set_instr(W_ECALL);
        mis_st = 1;
        settle();
        advance();
        clear_inputs();
        settle();
        chk("ecall_cause", cause, 4'd11);
        advance();

        // Interrupt versus illegal
        mie = 1; mtie = 1; mtip = 1; meie = 1; meip = 1;
        illegal = 1;
        settle();
        advance();
        clear_inputs();
        settle();
`ifdef MSRV32_INTERRUPTS_EN
        chk("irq_cause", cause, 4'd11);
        chk("irq_i_or_e", i_or_e, 1'b1);
`else
        chk("irq_cause", cause, 4'd2);
        chk("irq_i_or_e", i_or_e, 1'b0);
`endif
        advance();

        // MRET
        set_instr(W_MRET);
        settle();
        chk("mret_no_trap", trap_taken, 1'b0);
        advance();
        clear_inputs();
        settle();
        chk("mret_pc_src", pc_src, 2'b01);
        chk("mret_mie_set", mie_set, 1'b1);
        chk("mret_flush", flush, 1'b1);
        advance();
        settle();
        chk("mret_back_pc_src", pc_src, 2'b11);
        advance();

        // MRET with illegal: trap wins
        set_instr(W_MRET);
        illegal = 1;
        settle();
        advance();
        clear_inputs();
        settle();
        chk("mret_ill_pc_src", pc_src, 2'b10);
        chk("mret_ill_cause", cause, 4'd2);
        advance();

        // Stall holds everything
        stall = 1; illegal = 1;
        settle();
        chk("stall_trap_taken", trap_taken, 1'b0);
        chk("stall_instret", instret, 1'b0);
        advance();
        settle();
        chk("stall_pc_src", pc_src, 2'b11);
        stall = 0;
        settle();
        chk("unstall_trap_taken", trap_taken, 1'b1);
        advance();
        clear_inputs();
        stall = 1;
        settle();
        chk("stall_tt_set_epc", set_epc, 1'b0);
        advance();
        settle();
        chk("stall_tt_pc_src", pc_src, 2'b10);
        stall = 0;
        settle();
        chk("tt_set_epc", set_epc, 1'b1);

        // Reset in the middle of trap entry
        rst_n = 1'b0;
        model_reset();
        settle();
        chk("midrst_pc_src", pc_src, 2'b00);
        chk("midrst_set_epc", set_epc, 1'b0);
        chk("midrst_cause", cause, 4'd0);
        advance();
        rst_n = 1'b1;
        settle();
        advance();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            randomize_inputs();
            settle();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                settle();
                advance();
                rst_n = 1'b1;
                settle();
            end
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
